ddr_cmd_sequencer: RTL
======================

Name: ddr_cmd_sequencer

Overview:
- Initiator side of the DDR1 command/data interface. It drives the memory array model's command pins and address/bank bus, sources write beats and captures read beats.
- Accepts single-burst host requests (valid/ready) with a flat address {ba,row,col}. Per bank it tracks the open row and issues LOAD MODE, ACTIVE, PRECHARGE, READ and WRITE with tMRD/tRP/tRCD/CAS-latency timing.
- Data is modelled one beat per clk (single-edge abstraction of the DDR data bus).

Parameters:
ROW_WIDTH, 14, row address bits
COL_WIDTH, 10, column address bits
BL, 4, burst length; legal values 2, 4, 8; mode code 1/2/3
BURST_TYPE, 0, 0 = sequential, 1 = interleaved (mode register bit a[3])
CL, 2, CAS latency in clk cycles from READ command to first read beat (2..3)
T_MRD, 2, clk cycles after LOAD MODE
T_RP, 3, clk cycles PRECHARGE->ACTIVE
T_RCD, 3, clk cycles ACTIVE->READ/WRITE

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  host request valid
req_ready  out  1  sequencer can accept a request
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  2+ROW_WIDTH+COL_WIDTH  {ba, row, col}
wdata  in  16  write beat from host
wdata_ack  out  1  wdata consumed this cycle
rdata  out  16  captured read beat
rdata_valid  out  1  rdata valid this cycle
cs_n, ras_n, cas_n, we_n  out  1 each  DDR command pins
ba  out  2  bank address
a  out  max(ROW_WIDTH,11)  address bus (row on ACTIVE, col on READ/WRITE, mode on LOAD MODE)
dq_out  out  16  write data to array
dq_in  in  16  read data from array
init_done  out  1  initialisation complete

Behaviour:
- Command encoding {cs_n,ras_n,cas_n,we_n}: NOP=0111, ACT=0011, READ=0101, WRITE=0100, PRE=0010, MRS=0000.
- Reset values: all command pins NOP; ba=0, a=0, dq_out=0; req_ready, wdata_ack, rdata_valid, init_done all 0; rdata=0. Open-row table cleared to all banks closed.
- Reset asserted mid-burst aborts immediately; after release the FSM restarts at INIT.
- INIT state, entered on first clk after reset release: issue MRS for one cycle with a[2:0]=BL code, a[3]=BURST_TYPE, a[6:4]=CL, other bits 0. Wait T_MRD cycles, set init_done=1, go to IDLE.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) latches write, bank, row and col, drops req_ready the next cycle and selects the path:
  - bank open, same row (hit) -> RW
  - bank closed -> ACT
  - bank open, different row (miss) -> PRE
- PRE: one-cycle PRE on ba, a[10]=0, then T_RP-1 NOPs, then ACT.
- ACT: one-cycle ACT with a=row, record row open, then T_RCD-1 NOPs, then RW.
- RW: one-cycle READ/WRITE, a=col with a[10]=0, then BURST.
- Write burst: dq_out=wdata and wdata_ack=1 in the WRITE cycle and on each of the next BL-1 cycles. Exactly BL acks per request.
- Read burst: rdata=dq_in and rdata_valid=1 for BL consecutive cycles starting CL cycles after the READ cycle.
- After the last beat, return to IDLE; req_ready rises the following cycle.
- Only one request is outstanding at a time. req_valid while req_ready=0 is ignored and must be held by the host.
- Column wrap within a burst is performed by the array; the sequencer always issues the unmodified col.
- Idle cycles drive NOP.

Optional Feature:
AUTO_PRECHARGE_EN
- Defined: READ/WRITE are issued with a[10]=1, and the bank is marked closed after the burst. Every request therefore takes the ACT path and the PRE state is never entered. Return to IDLE is delayed T_RP cycles after the last beat.
- Undefined: open-page policy as described above, a[10]=0.

Decomposition:
- Package ddr_pkg holds:
  - ddr_cmd_e enum (NOP, ACT, READ, WRITE, PRE, MRS) with pin-encoding function
  - BL-to-mode-code function
  - ADDR_W localparam
  - FSM state enum (INIT, INIT_WAIT, IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, BURST)
- Sub-module ddr_bank_tracker: 4-entry open-flag/row table with lookup (hit/miss/closed) and open/close/clear ports.

Test Plan:
- Reset release with BL=4, BURST_TYPE=0, CL=2 -> MRS with a[6:0]=7'b0100010 one cycle later; init_done=1 after T_MRD cycles.
- Write ba=1, row=5, col=8, wdata 16'hA0..A3 -> ACT(row 5), 3 cycles later WRITE(col 8); wdata_ack high 4 cycles; array holds A0..A3 at cols 8..11.
- Read of the same address -> no ACT, READ immediately; rdata_valid high 4 cycles starting 2 cycles after READ; data A0..A3.
- Read ba=1, row=6 (row miss) -> PRE ba=1, ACT row 6 three cycles later, READ three cycles after that.
- rst asserted during write beat 2 -> pins NOP and outputs at reset values immediately; INIT MRS re-issued; a subsequent read of ba=1 requires ACT.
- AUTO_PRECHARGE_EN: two back-to-back reads to ba=0, row=3 -> both READs carry a[10]=1; both preceded by ACT; no PRE command is issued.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and helpers for the DDR command sequencer: command encodings,
// FSM states, bank lookup results and mode-register helpers.
package ddr_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_READ,
    CMD_WRITE,
    CMD_PRE,
    CMD_MRS
  } ddr_cmd_e;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_PRE,
    ST_WAIT_RP,
    ST_ACT,
    ST_WAIT_RCD,
    ST_RW,
    ST_BURST
  } ddr_state_e;

  typedef enum logic [1:0] {
    LK_CLOSED,
    LK_HIT,
    LK_MISS
  } bank_lookup_e;

  // The address bus must carry a[10] even when rows are narrower than 11 bits.
  function automatic int addr_width(input int row_w);
    return (row_w > 11) ? row_w : 11;
  endfunction

  localparam int ADDR_W = addr_width(14);

  // {cs_n, ras_n, cas_n, we_n}
  function automatic logic [3:0] cmd_pins(input ddr_cmd_e c);
    case (c)
      CMD_ACT:   return 4'b0011;
      CMD_READ:  return 4'b0101;
      CMD_WRITE: return 4'b0100;
      CMD_PRE:   return 4'b0010;
      CMD_MRS:   return 4'b0000;
      default:   return 4'b0111;
    endcase
  endfunction

  function automatic logic [2:0] bl_code(input int bl);
    case (bl)
      2:       return 3'd1;
      8:       return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// Four-entry open-row table: reports hit/miss/closed for a bank/row and
// accepts open, close and clear-all updates.
module ddr_bank_tracker
  import ddr_pkg::*;
#(
  parameter int ROW_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           lookup_ba_i,
  input  logic [ROW_WIDTH-1:0] lookup_row_i,
  output bank_lookup_e         lookup_o,
  input  logic                 open_i,
  input  logic [1:0]           open_ba_i,
  input  logic [ROW_WIDTH-1:0] open_row_i,
  input  logic                 close_i,
  input  logic [1:0]           close_ba_i,
  input  logic                 clear_i
);

  logic [3:0]           open_flags;
  logic [ROW_WIDTH-1:0] rows [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic                 open_q;
      logic [ROW_WIDTH-1:0] row_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          open_q <= 1'b0;
          row_q  <= '0;
        end else if (clear_i) begin
          open_q <= 1'b0;
        end else if (open_i && (open_ba_i == 2'(gi))) begin
          open_q <= 1'b1;
          row_q  <= open_row_i;
        end else if (close_i && (close_ba_i == 2'(gi))) begin
          open_q <= 1'b0;
        end
      end

      assign open_flags[gi] = open_q;
      assign rows[gi]       = row_q;
    end
  endgenerate

  always_comb begin
    lookup_o = LK_CLOSED;
    if (open_flags[lookup_ba_i]) begin
      lookup_o = (rows[lookup_ba_i] == lookup_row_i) ? LK_HIT : LK_MISS;
    end
  end

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// DDR1 initiator: mode-register init, per-bank open-page tracking and
// single-burst read/write sequencing. Define AUTO_PRECHARGE_EN for closed-page.
module ddr_cmd_sequencer
  import ddr_pkg::*;
#(
  parameter  int ROW_WIDTH  = 14,
  parameter  int COL_WIDTH  = 10,
  parameter  int BL         = 4,
  parameter  int BURST_TYPE = 0,
  parameter  int CL         = 2,
  parameter  int T_MRD      = 2,
  parameter  int T_RP       = 3,
  parameter  int T_RCD      = 3,
  localparam int AW         = addr_width(ROW_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_write_i,
  input  logic [2+ROW_WIDTH+COL_WIDTH-1:0] req_addr_i,
  input  logic [15:0]                    wdata_i,
  output logic                           wdata_ack_o,
  output logic [15:0]                    rdata_o,
  output logic                           rdata_valid_o,
  output logic                           cs_n_o,
  output logic                           ras_n_o,
  output logic                           cas_n_o,
  output logic                           we_n_o,
  output logic [1:0]                     ba_o,
  output logic [AW-1:0]                  a_o,
  output logic [15:0]                    dq_out_o,
  input  logic [15:0]                    dq_in_i,
  output logic                           init_done_o
);

`ifdef AUTO_PRECHARGE_EN
  localparam logic AP   = 1'b1;
  localparam int   TAIL = T_RP;
`else
  localparam logic AP   = 1'b0;
  localparam int   TAIL = 0;
`endif

  localparam logic [7:0] MRD_CNT  = 8'(T_MRD - 1);
  localparam logic [7:0] RP_CNT   = 8'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [7:0] RCD_CNT  = 8'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [7:0] BL_C     = 8'(BL);
  localparam logic [7:0] CL_C     = 8'(CL);
  localparam logic [7:0] CL_BL_C  = 8'(CL + BL);
  localparam logic [7:0] WR_DONE  = 8'(BL + TAIL);
  localparam logic [7:0] RD_DONE  = 8'(CL + BL + TAIL);

  ddr_state_e           state_q;
  logic [7:0]           cnt_q;
  logic                 wr_q;
  logic [1:0]           ba_q;
  logic [ROW_WIDTH-1:0] row_q;
  logic [COL_WIDTH-1:0] col_q;
  logic [3:0]           pins_q;
  logic [1:0]           ba_out_q;
  logic [AW-1:0]        a_q;
  logic                 req_ready_q;
  logic                 wack_q;
  logic                 rvalid_q;
  logic                 init_done_q;

  logic [1:0]           req_ba_d;
  logic [ROW_WIDTH-1:0] req_row_d;
  logic [COL_WIDTH-1:0] req_col_d;
  logic [AW-1:0]        mode_d;
  logic [AW-1:0]        row_addr_d;
  logic [AW-1:0]        col_addr_d;
  logic [7:0]           done_off_d;
  logic                 burst_end_d;
  bank_lookup_e         lookup;

  assign req_ba_d    = req_addr_i[ROW_WIDTH+COL_WIDTH +: 2];
  assign req_row_d   = req_addr_i[COL_WIDTH +: ROW_WIDTH];
  assign req_col_d   = req_addr_i[COL_WIDTH-1:0];
  assign done_off_d  = wr_q ? WR_DONE : RD_DONE;
  assign burst_end_d = (state_q == ST_BURST) && (cnt_q == done_off_d);

  always_comb begin
    mode_d      = '0;
    mode_d[2:0] = bl_code(BL);
    mode_d[3]   = 1'(BURST_TYPE);
    mode_d[6:4] = 3'(CL);
    row_addr_d  = '0;
    row_addr_d[ROW_WIDTH-1:0] = row_q;
    col_addr_d  = '0;
    col_addr_d[COL_WIDTH-1:0] = col_q;
    col_addr_d[10] = AP;
  end

  ddr_bank_tracker #(.ROW_WIDTH(ROW_WIDTH)) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .lookup_ba_i  (req_ba_d),
    .lookup_row_i (req_row_d),
    .lookup_o     (lookup),
    .open_i       (state_q == ST_ACT),
    .open_ba_i    (ba_q),
    .open_row_i   (row_q),
    .close_i      (AP && burst_end_d),
    .close_ba_i   (ba_q),
    .clear_i      (state_q == ST_INIT)
  );

  // Wait states count down to zero; BURST counts up the offset from the RW cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pins_q      <= cmd_pins(CMD_NOP);
      ba_out_q    <= '0;
      a_q         <= '0;
      req_ready_q <= 1'b0;
      wack_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      pins_q <= cmd_pins(CMD_NOP);
      case (state_q)
        ST_INIT: begin
          pins_q   <= cmd_pins(CMD_MRS);
          ba_out_q <= '0;
          a_q      <= mode_d;
          cnt_q    <= MRD_CNT;
          state_q  <= ST_INIT_WAIT;
        end
        ST_INIT_WAIT: begin
          if (cnt_q == '0) begin
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            wr_q        <= req_write_i;
            ba_q        <= req_ba_d;
            row_q       <= req_row_d;
            col_q       <= req_col_d;
            case (lookup)
              LK_HIT:  state_q <= ST_RW;
              LK_MISS: state_q <= ST_PRE;
              default: state_q <= ST_ACT;
            endcase
          end
        end
        ST_PRE: begin
          pins_q   <= cmd_pins(CMD_PRE);
          ba_out_q <= ba_q;
          a_q      <= '0;
          cnt_q    <= RP_CNT;
          state_q  <= (T_RP > 1) ? ST_WAIT_RP : ST_ACT;
        end
        ST_WAIT_RP: begin
          if (cnt_q == '0) state_q <= ST_ACT;
          else             cnt_q   <= cnt_q - 8'd1;
        end
        ST_ACT: begin
          pins_q   <= cmd_pins(CMD_ACT);
          ba_out_q <= ba_q;
          a_q      <= row_addr_d;
          cnt_q    <= RCD_CNT;
          state_q  <= (T_RCD > 1) ? ST_WAIT_RCD : ST_RW;
        end
        ST_WAIT_RCD: begin
          if (cnt_q == '0) state_q <= ST_RW;
          else             cnt_q   <= cnt_q - 8'd1;
        end
        ST_RW: begin
          pins_q   <= wr_q ? cmd_pins(CMD_WRITE) : cmd_pins(CMD_READ);
          ba_out_q <= ba_q;
          a_q      <= col_addr_d;
          wack_q   <= wr_q;
          cnt_q    <= 8'd1;
          state_q  <= ST_BURST;
        end
        ST_BURST: begin
          wack_q   <= wr_q && (cnt_q < BL_C);
          rvalid_q <= !wr_q && (cnt_q >= CL_C) && (cnt_q < CL_BL_C);
          cnt_q    <= cnt_q + 8'd1;
          if (burst_end_d) begin
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign {cs_n_o, ras_n_o, cas_n_o, we_n_o} = pins_q;
  assign ba_o          = ba_out_q;
  assign a_o           = a_q;
  assign req_ready_o   = req_ready_q;
  assign init_done_o   = init_done_q;
  assign wdata_ack_o   = wack_q;
  assign rdata_valid_o = rvalid_q;
  // Beats pass straight between host and array during their marked cycles.
  assign dq_out_o      = wack_q ? wdata_i : 16'h0000;
  assign rdata_o       = rvalid_q ? dq_in_i : 16'h0000;

endmodule
